// File: rtl/cla_mod_counter_pkg.sv
// ==================================================================
// Module   : cla_mod_counter_pkg
// Purpose  : shared encodings and helpers for the modulo counter
// Revision : 1.0
// ==================================================================
`default_nettype none

package cla_mod_counter_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Loaded values never exceed the terminal value, so count stays in 0..mod_max.
  function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] val,
                                                    input logic [WIDTH-1:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_incr4.sv
// ==================================================================
// Module   : cla_incr4
// Purpose  : combinational 4-bit carry-lookahead add-one (P=a, G=0, C0=1)
// Revision : 1.0
// ==================================================================
`default_nettype none

module cla_incr4 (
  input  logic [3:0] a,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_carry;

  assign w_carry[0] = 1'b1;

  // With G=0 and C0=1 every lookahead carry collapses to the AND of the lower bits.
  generate
    for (genvar i = 1; i <= 4; i++) begin : g_carry
      assign w_carry[i] = &a[i-1:0];
    end
  endgenerate

  assign sum  = a ^ w_carry[3:0];
  assign cout = w_carry[4];

endmodule

`default_nettype wire

// File: rtl/cla_mod_counter.sv
// ==================================================================
// Module   : cla_mod_counter
// Purpose  : 4-bit programmable modulo counter, free-run or one-shot
// Revision : 1.0
// ==================================================================
`default_nettype none

module cla_mod_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  import cla_mod_counter_pkg::*;

  state_t           r_state;
  logic             r_mode;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_next;
  logic             w_cout;
  logic             w_at_max;

  cla_incr4 u_incr (
    .a    (r_count),
    .sum  (w_next),
    .cout (w_cout)
  );

  // cout only rises at 4'hF, which already satisfies count >= mod_max.
  assign w_at_max = (r_count >= mod_max) | w_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_FREE;
      r_count <= RESET_VAL;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_count <= clamp_to_max(load_val, mod_max);
        if (start) begin
          r_state <= ST_RUN;
          r_mode  <= mode;
        end
      end else if (start) begin
        r_count <= '0;
        r_mode  <= mode;
        r_state <= ST_RUN;
      end else if (stop) begin
        r_state <= ST_IDLE;
      end else if ((r_state == ST_RUN) && en) begin
        if (w_at_max) begin
          if (r_mode == MODE_ONESHOT) begin
            r_state <= ST_DONE;
          end else begin
            r_count <= '0;
            r_tc    <= 1'b1;
          end
        end else begin
          r_count <= w_next;
        end
      end
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);

endmodule

`default_nettype wire
